mvm_sequencer: RTL and testbench

Parameterised control path for the matrix-vector-multiply layer datapath: X vector memory, per-MAC weight and bias ROMs, P pipelined MAC units with ReLU, and an output select mux. It streams N input words into X memory, then walks M/P row groups. For each group it issues weight and bias addresses, times the bias load and accumulate enables against the fixed datapath pipeline, and serialises the P results onto the output stream. It sits beside the datapath inside each generated layer_* top.

---
 rtl/mvm_pkg.sv | 18 +
 rtl/mvm_out_serializer.sv | 39 +++
 rtl/mvm_sequencer.sv | 146 ++++++++++++++
 tb/tb_mvm_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector-multiply sequencer.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        OUT
    } state_t;

    // ROM/memory read (1) plus product pipe register (1).
    localparam int unsigned PIPE_LAT = 2;

    function automatic int unsigned max1_clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mvm_out_serializer.sv
// Output beat counter: walks the P MAC results onto the output stream
// under the m_valid/m_ready handshake.
module mvm_out_serializer
    import mvm_pkg::*;
#(
    parameter int unsigned P = 1,
    localparam int unsigned SW = max1_clog2(P)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [SW-1:0] sel_out,
    output logic          last_beat
);

    localparam logic [SW-1:0] LAST_SEL = SW'(P - 1);

    assign last_beat = m_valid & m_ready & (sel_out == LAST_SEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            sel_out <= '0;
        end else if (start) begin
            m_valid <= 1'b1;
            sel_out <= '0;
        end else if (m_valid && m_ready) begin
            if (sel_out == LAST_SEL) begin
                m_valid <= 1'b0;
                sel_out <= '0;
            end else begin
                sel_out <= sel_out + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvm_sequencer.sv
// Control path for the matrix-vector-multiply layer: loads X, walks M/P row
// groups through the MAC pipeline and hands results to the output serializer.
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int unsigned M = 16,
    parameter int unsigned N = 8,
    parameter int unsigned P = 1,
    localparam int unsigned G    = M / P,
    localparam int unsigned AW_X = max1_clog2(N),
    localparam int unsigned AW_W = max1_clog2(G * N),
    localparam int unsigned AW_B = max1_clog2(G),
    localparam int unsigned SW   = max1_clog2(P)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            wr_en_x,
    output logic [AW_X-1:0] addr_X,
    output logic [AW_W-1:0] addr_W,
    output logic [AW_B-1:0] addr_B,
    output logic            accum_src,
    output logic            en,
    output logic [SW-1:0]   sel_out,
    output logic            done
);

    if (M % P != 0) begin : g_bad_p
        $error("mvm_sequencer: M must be a multiple of P");
    end

    localparam int unsigned TW = max1_clog2(N + PIPE_LAT);
    localparam logic [TW-1:0]   T_BIAS = TW'(PIPE_LAT - 1);
    localparam logic [TW-1:0]   T_LAST = TW'(N + PIPE_LAT - 1);
    localparam logic [TW-1:0]   T_N    = TW'(N);
    localparam logic [TW-1:0]   T_NM1  = TW'(N - 1);
    localparam logic [AW_X-1:0] K_LAST = AW_X'(N - 1);
    localparam logic [AW_B-1:0] G_LAST = AW_B'(G - 1);

    state_t          state;
    logic [AW_X-1:0] k;
    logic [TW-1:0]   t;
    logic [AW_B-1:0] g;
    logic [AW_W-1:0] w_ptr;
    logic            mac_last;
    logic            last_beat;

    assign wr_en_x  = s_valid & s_ready;
    assign mac_last = (state == MAC) && (t == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            t       <= '0;
            g       <= '0;
            w_ptr   <= '0;
            s_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                end
                LOAD: begin
                    if (wr_en_x) begin
                        if (k == K_LAST) begin
                            k       <= '0;
                            g       <= '0;
                            t       <= '0;
                            w_ptr   <= '0;
                            s_ready <= 1'b0;
                            state   <= MAC;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                MAC: begin
                    // w_ptr parks on the group's last column; the step into the
                    // next group happens on the OUT->MAC transition so it never
                    // runs past G*N-1.
                    if (t < T_NM1) begin
                        w_ptr <= w_ptr + 1'b1;
                    end
                    if (mac_last) begin
                        t     <= '0;
                        state <= OUT;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                OUT: begin
                    if (last_beat) begin
                        if (g == G_LAST) begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end else begin
                            g     <= g + 1'b1;
                            w_ptr <= w_ptr + 1'b1;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr_X    = '0;
        addr_W    = '0;
        addr_B    = '0;
        en        = 1'b0;
        accum_src = 1'b0;
        if (state == LOAD) begin
            addr_X = k;
        end else if (state == MAC) begin
            addr_B = g;
            if (t < T_N) begin
                addr_X = AW_X'(t);
                addr_W = w_ptr;
            end
            en        = (t != '0);
            accum_src = (t == T_BIAS);
        end
    end

    assign done = last_beat && (state == OUT) && (g == G_LAST);

    mvm_out_serializer #(
        .P(P)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .start    (mac_last),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .sel_out  (sel_out),
        .last_beat(last_beat)
    );

endmodule

// File: tb/tb_mvm_sequencer.sv
// Bench: two sequencers (P=1, P=4) with a behavioural datapath, scoreboarded outputs.
module tb_mvm_sequencer;

    localparam int M = 16;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] s_valid;
    logic [1:0] m_ready;
    int         s_data;

    logic [1:0]        s_ready_v, m_valid_v, wr_v, src_v, en_v, done_v;
    logic [1:0][15:0]  ax_v, aw_v, ab_v, sel_v;
    logic [1:0][31:0]  dout_v;

    int n_chk  = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];

    function automatic int wf(input int row, input int col);
        return ((row * 7 + col * 3) % 11) - 5;
    endfunction

    function automatic int bf(input int row);
        return ((row * 5) % 9) * 4 - 16;
    endfunction

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int expect_row(input int r, input int xs[8]);
        int a;
        a = bf(r);
        for (int n = 0; n < N; n++) a += wf(r, n) * xs[n];
        return relu(a);
    endfunction

    for (genvar c = 0; c < 2; c++) begin : cfg
        localparam int P    = (c == 0) ? 1 : 4;
        localparam int G    = M / P;
        localparam int AW_X = (N > 1) ? $clog2(N) : 1;
        localparam int AW_W = (G * N > 1) ? $clog2(G * N) : 1;
        localparam int AW_B = (G > 1) ? $clog2(G) : 1;
        localparam int SW   = (P > 1) ? $clog2(P) : 1;

        logic            s_ready, m_valid, wr_en_x, accum_src, en, done;
        logic [AW_X-1:0] addr_X;
        logic [AW_W-1:0] addr_W;
        logic [AW_B-1:0] addr_B;
        logic [SW-1:0]   sel_out;

        mvm_sequencer #(.M(M), .N(N), .P(P)) dut (
            .clk      (clk),
            .reset    (reset),
            .s_valid  (s_valid[c]),
            .s_ready  (s_ready),
            .m_valid  (m_valid),
            .m_ready  (m_ready[c]),
            .wr_en_x  (wr_en_x),
            .addr_X   (addr_X),
            .addr_W   (addr_W),
            .addr_B   (addr_B),
            .accum_src(accum_src),
            .en       (en),
            .sel_out  (sel_out),
            .done     (done)
        );

        int xmem[N];
        int x_rd;
        int w_rd[P];
        int b_rd[P];
        int prod[P];
        int acc[P];

        always @(posedge clk) begin
            if (wr_en_x) xmem[addr_X] <= s_data;
            x_rd <= xmem[addr_X];
            for (int p = 0; p < P; p++) begin
                w_rd[p] <= wf(int'(addr_W) / N * P + p, int'(addr_W) % N);
                b_rd[p] <= bf(int'(addr_B) * P + p);
                prod[p] <= x_rd * w_rd[p];
                if (en) acc[p] <= accum_src ? b_rd[p] : acc[p] + prod[p];
            end
        end

        assign s_ready_v[c] = s_ready;
        assign m_valid_v[c] = m_valid;
        assign wr_v[c]      = wr_en_x;
        assign src_v[c]     = accum_src;
        assign en_v[c]      = en;
        assign done_v[c]    = done;
        assign ax_v[c]      = 16'(addr_X);
        assign aw_v[c]      = 16'(addr_W);
        assign ab_v[c]      = 16'(addr_B);
        assign sel_v[c]     = 16'(sel_out);
        assign dout_v[c]    = 32'(relu(acc[sel_out]));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int c);
        check("rst_s_ready", s_ready_v[c], 0);
        check("rst_m_valid", m_valid_v[c], 0);
        check("rst_wr_en_x", wr_v[c], 0);
        check("rst_en", en_v[c], 0);
        check("rst_accum_src", src_v[c], 0);
        check("rst_done", done_v[c], 0);
        check("rst_addr_X", ax_v[c], 0);
        check("rst_addr_W", aw_v[c], 0);
        check("rst_addr_B", ab_v[c], 0);
        check("rst_sel_out", sel_v[c], 0);
    endtask

    // Drives one vector starting in a LOAD cycle; returns the number of cycles
    // from LOAD entry through the done beat, or aborts at MAC t==5 of abort_g.
    task automatic run_vector(input int c, input int xs[8], input bit toggle,
                              input int stall_at, input bit hold, input int hold_word,
                              input int abort_g, output int cyc, output bit aborted);
        int P, G, loaded, g, mt, beats, outs, stall, exp_v;
        bit finished, in_out;
        P = (c == 0) ? 1 : 4;
        G = M / P;
        aborted = 0;
        for (int r = 0; r < M; r++) begin
            if (c == 0) q0.push_back(expect_row(r, xs));
            else        q1.push_back(expect_row(r, xs));
        end

        loaded = 0;
        cyc = 0;
        while (loaded < N && cyc < 100) begin
            s_valid[c] = toggle ? (cyc % 2 == 0) : 1'b1;
            s_data     = xs[loaded];
            m_ready[c] = 1'b1;
            #1;
            check("ld_s_ready", s_ready_v[c], 1);
            check("ld_wr_en_x", wr_v[c], s_valid[c]);
            check("ld_m_valid", m_valid_v[c], 0);
            check("ld_en", en_v[c], 0);
            if (s_valid[c]) check("ld_addr_X", ax_v[c], loaded);
            tick();
            if (s_valid[c]) loaded++;
            cyc++;
        end
        if (loaded < N) check("ld_timeout", loaded, N);

        g = 0; mt = 0; beats = 0; outs = 0; stall = 0; finished = 0;
        s_valid[c] = hold;
        s_data     = hold_word;
        while (!finished && cyc < 600) begin
            in_out = (mt == N + 2);
            if (!in_out && g == abort_g && mt == 5) begin
                aborted = 1;
                return;
            end
            m_ready[c] = !(in_out && outs == stall_at && stall < 5);
            #1;
            check("run_s_ready", s_ready_v[c], 0);
            check("run_wr_en_x", wr_v[c], 0);
            if (!in_out) begin
                check("mac_m_valid", m_valid_v[c], 0);
                check("mac_en", en_v[c], mt >= 1);
                check("mac_accum_src", src_v[c], mt == 1);
                check("mac_addr_B", ab_v[c], g);
                check("mac_done", done_v[c], 0);
                if (mt < N) begin
                    check("mac_addr_W", aw_v[c], g * N + mt);
                    check("mac_addr_X", ax_v[c], mt);
                end
            end else begin
                exp_v = (c == 0) ? q0[0] : q1[0];
                check("out_m_valid", m_valid_v[c], 1);
                check("out_sel", sel_v[c], beats);
                check("out_en", en_v[c], 0);
                check("out_data", dout_v[c], exp_v);
                if (m_ready[c]) begin
                    if (c == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    check("out_done", done_v[c], outs == M - 1);
                    outs++;
                    beats++;
                end else begin
                    check("stall_done", done_v[c], 0);
                    stall++;
                end
            end
            tick();
            cyc++;
            if (!in_out) mt++;
            else if (beats == P) begin
                beats = 0;
                if (g == G - 1) finished = 1;
                else begin
                    g++;
                    mt = 0;
                end
            end
        end
        if (!finished) check("out_timeout", outs, M);
    endtask

    initial begin : main
        int v_a[8], v_b[8], v_c[8], v_d[8];
        int cyc;
        bit ab;
        v_a = '{1, 2, 3, 4, 5, 6, 7, 8};
        v_b = '{8, -3, 6, 1, -7, 2, 5, -4};
        v_c = '{-2, 9, 0, 3, 3, -8, 1, 6};
        v_d = '{11, 4, -5, 7, 2, 0, -9, 3};

        reset   = 1'b1;
        s_valid = '0;
        m_ready = '0;
        s_data  = 0;
        #12;
        check_zero(0);
        check_zero(1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("idle_s_ready0", s_ready_v[0], 0);
        check("idle_s_ready1", s_ready_v[1], 0);
        tick();

        run_vector(0, v_a, 0, -1, 0, 0, -1, cyc, ab);
        check("latency_p1", cyc, N + 16 * (N + 2 + 1));
        run_vector(0, v_b, 1, -1, 0, 0, -1, cyc, ab);
        run_vector(0, v_c, 0, 3, 0, 0, -1, cyc, ab);
        check("latency_stall", cyc, N + 16 * (N + 2 + 1) + 5);
        run_vector(0, v_a, 0, -1, 1, v_d[0], -1, cyc, ab);
        run_vector(0, v_d, 0, -1, 0, 0, 2, cyc, ab);
        check("abort_reached", ab, 1);

        reset = 1'b1;
        #1;
        check_zero(0);
        q0.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rel_idle", s_ready_v[0], 0);
        tick();
        run_vector(0, v_b, 0, -1, 0, 0, -1, cyc, ab);
        check("latency_after_rst", cyc, N + 16 * (N + 2 + 1));

        run_vector(1, v_a, 0, -1, 0, 0, -1, cyc, ab);
        check("latency_p4", cyc, N + 4 * (N + 2 + 4));
        run_vector(1, v_c, 1, 2, 0, 0, -1, cyc, ab);
        check("q_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
